// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared types for the AXI4-Lite subordinate-to-memory bridge:
//   - AXI response codes (OKAY / SLVERR)
//   - controller state enum
//   - helper that classifies a request address as in/out of range or misaligned
// No ports (package).
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_slverr = 2'b10
    } axi_resp_e;

    typedef enum logic [2:0] {
        e_idle,
        e_rd_cmd,
        e_rd_wait,
        e_rd_resp,
        e_wr_cmd,
        e_wr_resp
    } axi_sub_state_e;

    // Byte offset bits inside one 64-bit word.
    localparam int unsigned axi_word_shift_lp = 3;

    // A request is rejected when it lies at/above the memory size or is not
    // aligned to a 64-bit word. The address is widened to 64 bits so a region
    // that covers the entire address space never reports out-of-range.
    function automatic logic addr_error(input logic [63:0] addr,
                                        input logic [63:0] limit);
        return (addr >= limit) || (addr[axi_word_shift_lp-1:0] != '0);
    endfunction

endpackage

// File: rtl/axi4_lite_sub_wr_capture.sv
// -----------------------------------------------------------------------------
// axi4_lite_sub_wr_capture
// One-entry holding registers for the AXI4-Lite AW and W channels. Each channel
// fills independently (either order, or the same cycle) and both empty together
// when the write is retired.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   en_i                  channels may accept a beat this cycle
//   clr_i                 empty both entries (write retired or rejected)
//   awaddr_i/awprot_i/awvalid_i/awready_o   AW channel
//   wdata_i/wstrb_i/wvalid_i/wready_o       W channel
//   aw_full_o, w_full_o   entry occupied flags
//   aw_addr_o, aw_prot_o  captured write address / protection
//   w_data_o, w_strb_o    captured write data / strobes
// -----------------------------------------------------------------------------
module axi4_lite_sub_wr_capture #(
    parameter int axi_addr_width_p  = 28,
    parameter int axi_data_width_p  = 64,
    parameter int axi_wstrb_width_p = axi_data_width_p / 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         en_i,
    input  logic                         clr_i,
    input  logic [axi_addr_width_p-1:0]  awaddr_i,
    input  logic [2:0]                   awprot_i,
    input  logic                         awvalid_i,
    output logic                         awready_o,
    input  logic [axi_data_width_p-1:0]  wdata_i,
    input  logic [axi_wstrb_width_p-1:0] wstrb_i,
    input  logic                         wvalid_i,
    output logic                         wready_o,
    output logic                         aw_full_o,
    output logic                         w_full_o,
    output logic [axi_addr_width_p-1:0]  aw_addr_o,
    output logic [2:0]                   aw_prot_o,
    output logic [axi_data_width_p-1:0]  w_data_o,
    output logic [axi_wstrb_width_p-1:0] w_strb_o
);

    logic                         aw_full_q;
    logic                         w_full_q;
    logic [axi_addr_width_p-1:0]  aw_addr_q;
    logic [2:0]                   aw_prot_q;
    logic [axi_data_width_p-1:0]  w_data_q;
    logic [axi_wstrb_width_p-1:0] w_strb_q;

    assign awready_o = en_i & ~aw_full_q;
    assign wready_o  = en_i & ~w_full_q;

    // Clear only happens when both entries are full, so it never collides with
    // a capture on the same cycle (capture needs the entry to be empty).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (clr_i) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
        end else begin
            if (awvalid_i && awready_o) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= awaddr_i;
                aw_prot_q <= awprot_i;
            end
            if (wvalid_i && wready_o) begin
                w_full_q <= 1'b1;
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
            end
        end
    end

    assign aw_full_o = aw_full_q;
    assign w_full_o  = w_full_q;
    assign aw_addr_o = aw_addr_q;
    assign aw_prot_o = aw_prot_q;
    assign w_data_o  = w_data_q;
    assign w_strb_o  = w_strb_q;

endmodule

// File: rtl/axi4_lite_sub_to_mem.sv
// -----------------------------------------------------------------------------
// axi4_lite_sub_to_mem
// AXI4-Lite subordinate that serialises single-beat 64-bit reads and writes
// onto a valid/ready memory command port and returns R/B responses. Exactly one
// transaction is outstanding at a time; reads and writes contending in idle are
// served round-robin.
//
// Optional feature (macro AXI4_LITE_SUB_PROT_CHECK_EN): when defined, any request
// with prot[0]==0 (unprivileged) is answered with SLVERR and skips memory.
// When undefined the prot inputs are ignored.
//
// Ports:
//   clk_i, reset_i                      clock, asynchronous active-high reset
//   ar*/r*                              AXI4-Lite read address / data channels
//   aw*/w*/b*                           AXI4-Lite write address / data / resp
//   mem_v_o, mem_w_o, mem_addr_o,       memory command (word address), accepted
//   mem_data_o, mem_mask_o,             when mem_v_o & mem_ready_and_i
//   mem_ready_and_i
//   mem_data_i, mem_data_v_i            read return, single-cycle pulse
//   rd_error_o, wr_error_o              sticky: an SLVERR was delivered on R / B
// -----------------------------------------------------------------------------
module axi4_lite_sub_to_mem
    import axi4_lite_pkg::*;
#(
    parameter int          axi_addr_width_p  = 28,
    parameter int          axi_data_width_p  = 64,   // only 64 is supported
    parameter int          axi_wstrb_width_p = axi_data_width_p / 8,
    parameter logic [63:0] mem_bytes_p       = 64'(1) << axi_addr_width_p
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic [axi_addr_width_p-1:0]   araddr_i,
    input  logic [2:0]                    arprot_i,
    input  logic                          arvalid_i,
    output logic                          arready_o,
    output logic [axi_data_width_p-1:0]   rdata_o,
    output logic [1:0]                    rresp_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,

    input  logic [axi_addr_width_p-1:0]   awaddr_i,
    input  logic [2:0]                    awprot_i,
    input  logic                          awvalid_i,
    output logic                          awready_o,
    input  logic [axi_data_width_p-1:0]   wdata_i,
    input  logic [axi_wstrb_width_p-1:0]  wstrb_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    output logic [1:0]                    bresp_o,
    output logic                          bvalid_o,
    input  logic                          bready_i,

    output logic                          mem_v_o,
    output logic                          mem_w_o,
    output logic [axi_addr_width_p-4:0]   mem_addr_o,
    output logic [axi_data_width_p-1:0]   mem_data_o,
    output logic [axi_wstrb_width_p-1:0]  mem_mask_o,
    input  logic                          mem_ready_and_i,
    input  logic [axi_data_width_p-1:0]   mem_data_i,
    input  logic                          mem_data_v_i,

    output logic                          rd_error_o,
    output logic                          wr_error_o
);

    localparam int word_addr_width_lp = axi_addr_width_p - axi_word_shift_lp;

    axi_sub_state_e                 state_q;
    logic                           prio_wr_q;   // 0: read wins a tie, 1: write wins
    logic [word_addr_width_lp-1:0]  addr_q;
    logic [axi_data_width_p-1:0]    rdata_q;
    axi_resp_e                      resp_q;
    logic                           rd_error_q;
    logic                           wr_error_q;

    // Write capture outputs
    logic                           aw_full;
    logic                           w_full;
    logic [axi_addr_width_p-1:0]    aw_addr;
    logic [2:0]                     aw_prot;
    logic [axi_data_width_p-1:0]    w_data;
    logic [axi_wstrb_width_p-1:0]   w_strb;

    logic is_idle;
    logic wr_elig;
    logic rd_blocked;
    logic rd_go;
    logic wr_go;
    logic rd_err;
    logic wr_err;
    logic rd_prot_err;
    logic wr_prot_err;
    logic wr_clr;
    logic unused_prot;

    // ------------------------------------------------------------------
    // Protection check
    // ------------------------------------------------------------------
`ifdef AXI4_LITE_SUB_PROT_CHECK_EN
    assign rd_prot_err = ~arprot_i[0];
    assign wr_prot_err = ~aw_prot[0];
    assign unused_prot = ^{arprot_i[2:1], aw_prot[2:1]};
`else
    assign rd_prot_err = 1'b0;
    assign wr_prot_err = 1'b0;
    assign unused_prot = ^{arprot_i, aw_prot};
`endif

    // ------------------------------------------------------------------
    // Arbitration. Readies are forced low while reset is held so every
    // output reads 0 during reset.
    // ------------------------------------------------------------------
    assign is_idle    = (state_q == e_idle);
    assign wr_elig    = aw_full & w_full;
    assign rd_blocked = wr_elig & prio_wr_q;

    // AR is never buffered: it is only accepted on the cycle it is dispatched.
    assign arready_o  = is_idle & ~rd_blocked & ~reset_i;
    assign rd_go      = arvalid_i & arready_o;
    assign wr_go      = is_idle & wr_elig & ~rd_go & ~reset_i;

    assign rd_err = addr_error(64'(araddr_i), mem_bytes_p) | rd_prot_err;
    assign wr_err = addr_error(64'(aw_addr),  mem_bytes_p) | wr_prot_err;

    // Captured write is released once memory takes it, or immediately when
    // it is rejected at dispatch.
    assign wr_clr = (wr_go & wr_err) | ((state_q == e_wr_cmd) & mem_ready_and_i);

    axi4_lite_sub_wr_capture #(
        .axi_addr_width_p  (axi_addr_width_p),
        .axi_data_width_p  (axi_data_width_p),
        .axi_wstrb_width_p (axi_wstrb_width_p)
    ) wr_capture (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .en_i      (is_idle & ~reset_i),
        .clr_i     (wr_clr),
        .awaddr_i  (awaddr_i),
        .awprot_i  (awprot_i),
        .awvalid_i (awvalid_i),
        .awready_o (awready_o),
        .wdata_i   (wdata_i),
        .wstrb_i   (wstrb_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .aw_full_o (aw_full),
        .w_full_o  (w_full),
        .aw_addr_o (aw_addr),
        .aw_prot_o (aw_prot),
        .w_data_o  (w_data),
        .w_strb_o  (w_strb)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            prio_wr_q  <= 1'b0;
            addr_q     <= '0;
            rdata_q    <= '0;
            resp_q     <= e_axi_resp_okay;
            rd_error_q <= 1'b0;
            wr_error_q <= 1'b0;
        end else begin
            case (state_q)
                e_idle: begin
                    if (rd_go) begin
                        // Winning a tie hands priority to the write side.
                        if (wr_elig) prio_wr_q <= 1'b1;
                        addr_q  <= araddr_i[axi_addr_width_p-1:axi_word_shift_lp];
                        rdata_q <= '0;   // rejected reads return zero data
                        if (rd_err) begin
                            resp_q  <= e_axi_resp_slverr;
                            state_q <= e_rd_resp;
                        end else begin
                            resp_q  <= e_axi_resp_okay;
                            state_q <= e_rd_cmd;
                        end
                    end else if (wr_go) begin
                        if (arvalid_i) prio_wr_q <= 1'b0;
                        addr_q <= aw_addr[axi_addr_width_p-1:axi_word_shift_lp];
                        if (wr_err) begin
                            resp_q  <= e_axi_resp_slverr;
                            state_q <= e_wr_resp;
                        end else begin
                            resp_q  <= e_axi_resp_okay;
                            state_q <= e_wr_cmd;
                        end
                    end
                end
                e_rd_cmd: begin
                    if (mem_ready_and_i) state_q <= e_rd_wait;
                end
                e_rd_wait: begin
                    if (mem_data_v_i) begin
                        rdata_q <= mem_data_i;
                        state_q <= e_rd_resp;
                    end
                end
                e_rd_resp: begin
                    if (rready_i) begin
                        if (resp_q == e_axi_resp_slverr) rd_error_q <= 1'b1;
                        state_q <= e_idle;
                    end
                end
                e_wr_cmd: begin
                    if (mem_ready_and_i) state_q <= e_wr_resp;
                end
                e_wr_resp: begin
                    if (bready_i) begin
                        if (resp_q == e_axi_resp_slverr) wr_error_q <= 1'b1;
                        state_q <= e_idle;
                    end
                end
                default: state_q <= e_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state)
    // ------------------------------------------------------------------
    assign rvalid_o   = (state_q == e_rd_resp);
    assign rdata_o    = rdata_q;
    assign rresp_o    = rvalid_o ? resp_q : e_axi_resp_okay;
    assign bvalid_o   = (state_q == e_wr_resp);
    assign bresp_o    = bvalid_o ? resp_q : e_axi_resp_okay;

    assign mem_v_o    = (state_q == e_rd_cmd) | (state_q == e_wr_cmd);
    assign mem_w_o    = (state_q == e_wr_cmd);
    assign mem_addr_o = addr_q;
    assign mem_data_o = mem_w_o ? w_data : '0;
    assign mem_mask_o = mem_w_o ? w_strb : '0;

    assign rd_error_o = rd_error_q;
    assign wr_error_o = wr_error_q;

endmodule

// File: tb/tb_axi4_lite_sub_to_mem.sv
`timescale 1ns/1ps
module tb_axi4_lite_sub_to_mem;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [27:0] araddr_i;
    logic [2:0]  arprot_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [63:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [27:0] awaddr_i;
    logic [2:0]  awprot_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [63:0] wdata_i;
    logic [7:0]  wstrb_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [24:0] mem_addr_o;
    logic [63:0] mem_data_o;
    logic [7:0]  mem_mask_o;
    logic        mem_ready_and_i;
    logic [63:0] mem_data_i;
    logic        mem_data_v_i;
    logic        rd_error_o;
    logic        wr_error_o;

    always #5 clk = ~clk;

    axi4_lite_sub_to_mem #(
        .axi_addr_width_p (28),
        .axi_data_width_p (64),
        .axi_wstrb_width_p(8),
        .mem_bytes_p      (64'h1000)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .araddr_i       (araddr_i),
        .arprot_i       (arprot_i),
        .arvalid_i      (arvalid_i),
        .arready_o      (arready_o),
        .rdata_o        (rdata_o),
        .rresp_o        (rresp_o),
        .rvalid_o       (rvalid_o),
        .rready_i       (rready_i),
        .awaddr_i       (awaddr_i),
        .awprot_i       (awprot_i),
        .awvalid_i      (awvalid_i),
        .awready_o      (awready_o),
        .wdata_i        (wdata_i),
        .wstrb_i        (wstrb_i),
        .wvalid_i       (wvalid_i),
        .wready_o       (wready_o),
        .bresp_o        (bresp_o),
        .bvalid_o       (bvalid_o),
        .bready_i       (bready_i),
        .mem_v_o        (mem_v_o),
        .mem_w_o        (mem_w_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_mask_o     (mem_mask_o),
        .mem_ready_and_i(mem_ready_and_i),
        .mem_data_i     (mem_data_i),
        .mem_data_v_i   (mem_data_v_i),
        .rd_error_o     (rd_error_o),
        .wr_error_o     (wr_error_o)
    );

    int checks = 0;
    int errors = 0;

    logic [173:0] all_out;
    assign all_out = {arready_o, rdata_o, rresp_o, rvalid_o, awready_o, wready_o,
                      bresp_o, bvalid_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o,
                      mem_mask_o, rd_error_o, wr_error_o};

    // ---------------- memory model ----------------
    logic [63:0] memarr [0:511];
    int          rd_lat  = 1;
    int          rd_pend = 0;
    logic [63:0] rd_ret  = '0;
    int          cmd_cnt = 0;
    logic        log_w[$];
    logic [24:0] log_addr[$];
    logic [7:0]  last_mask = '0;

    always @(posedge clk) begin
        if (!reset_i && mem_v_o && mem_ready_and_i) begin
            cmd_cnt++;
            log_w.push_back(mem_w_o);
            log_addr.push_back(mem_addr_o);
            last_mask = mem_mask_o;
            if (mem_w_o) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_mask_o[b]) memarr[mem_addr_o[8:0]][b*8 +: 8] = mem_data_o[b*8 +: 8];
                end
            end else begin
                rd_ret  = memarr[mem_addr_o[8:0]];
                rd_pend = rd_lat;
            end
        end
        if (rvalid_o && bvalid_o) begin
            errors++;
            $display("FAIL rvalid_bvalid_overlap got rvalid=%0b bvalid=%0b want not both", rvalid_o, bvalid_o);
        end
    end

    initial begin
        mem_data_v_i = 1'b0;
        mem_data_i   = '0;
        forever begin
            @(posedge clk); #1;
            mem_data_v_i = 1'b0;
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin
                    mem_data_v_i = 1'b1;
                    mem_data_i   = rd_ret;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ar_send(input logic [27:0] a, output bit to);
        int n = 0;
        araddr_i = a; arvalid_i = 1'b1; to = 1'b0;
        while (!arready_o && n < 60) begin tick(); n++; end
        if (!arready_o) to = 1'b1;
        tick();
        arvalid_i = 1'b0;
    endtask

    task automatic wait_rvalid(output int n, output bit to);
        n = 0;
        while (!rvalid_o && n < 60) begin tick(); n++; end
        to = !rvalid_o;
    endtask

    task automatic wait_bvalid(output int n, output bit to);
        n = 0;
        while (!bvalid_o && n < 60) begin tick(); n++; end
        to = !bvalid_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i = 1'b1;
        araddr_i = '0; arprot_i = 3'b001; arvalid_i = 0; rready_i = 0;
        awaddr_i = '0; awprot_i = 3'b001; awvalid_i = 0;
        wdata_i = '0; wstrb_i = '0; wvalid_i = 0; bready_i = 0;
        mem_ready_and_i = 1'b1;
        for (int i = 0; i < 512; i++) memarr[i] = '0;
        tick(); tick();
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
        reset_i = 1'b0;
        tick();
        checks++;
        if ({arready_o, awready_o, wready_o} !== 3'b111) begin
            errors++; $display("FAIL post_reset_ready got %b want 111", {arready_o, awready_o, wready_o});
        end
        checks++;
        if ({rvalid_o, bvalid_o, mem_v_o} !== 3'b000) begin
            errors++; $display("FAIL post_reset_valids got %b want 000", {rvalid_o, bvalid_o, mem_v_o});
        end
        $display("reset: done");
    endtask

    task automatic test_read();
        bit to; int n;
        rd_lat = 3; memarr[8] = 64'hDEAD_BEEF_0000_0001; rready_i = 0;
        ar_send(28'h40, to);
        checks++;
        if (to) begin errors++; $display("FAIL read_ar_timeout got timeout want handshake"); end
        checks++;
        if ({mem_v_o, mem_w_o} !== 2'b10 || mem_addr_o !== 25'h8) begin
            errors++; $display("FAIL read_cmd got v/w=%b addr=%h want 10 addr=8", {mem_v_o, mem_w_o}, mem_addr_o);
        end
        wait_rvalid(n, to);
        checks++;
        if (to || rdata_o !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("FAIL read_data got %h want deadbeef00000001", rdata_o);
        end
        checks++;
        if (rresp_o !== 2'b00) begin errors++; $display("FAIL read_resp got %b want 00", rresp_o); end
        rready_i = 1; tick(); rready_i = 0;
        checks++;
        if (rvalid_o !== 1'b0 || arready_o !== 1'b1) begin
            errors++; $display("FAIL read_done got rvalid=%b arready=%b want 0 1", rvalid_o, arready_o);
        end
        rd_lat = 1;
        $display("read: addr 40 data %h resp %b", rdata_o, rresp_o);
    endtask

    task automatic test_write_w_first();
        bit to; int n; int base;
        memarr[32] = 64'h1111_1111_1111_1111; base = cmd_cnt;
        wdata_i = 64'hAAAA_BBBB_CCCC_DDDD; wstrb_i = 8'h0F; wvalid_i = 1;
        tick(); wvalid_i = 0;          // W captured
        tick();
        checks++;
        if (wready_o !== 1'b0 || cmd_cnt != base || mem_v_o !== 1'b0) begin
            errors++; $display("FAIL w_only got wready=%b cmds=%0d mem_v=%b want 0 %0d 0", wready_o, cmd_cnt - base, mem_v_o, 0);
        end
        awaddr_i = 28'h100; awvalid_i = 1;
        tick(); awvalid_i = 0;         // AW captured: write complete
        wait_bvalid(n, to);
        checks++;
        if (to || n != 2) begin errors++; $display("FAIL write_latency got %0d want 2", n); end
        checks++;
        if (cmd_cnt != base + 1 || log_w[$] !== 1'b1 || log_addr[$] !== 25'h20 || last_mask !== 8'h0F) begin
            errors++; $display("FAIL write_cmd got cnt=%0d addr=%h mask=%h want 1 20 0f", cmd_cnt - base, log_addr[$], last_mask);
        end
        checks++;
        if (bresp_o !== 2'b00) begin errors++; $display("FAIL write_resp got %b want 00", bresp_o); end
        checks++;
        if (memarr[32] !== 64'h1111_1111_CCCC_DDDD) begin
            errors++; $display("FAIL write_mem got %h want 11111111ccccdddd", memarr[32]);
        end
        bready_i = 1; tick(); bready_i = 0;
        checks++;
        if ({bvalid_o, awready_o, wready_o} !== 3'b011) begin
            errors++; $display("FAIL write_done got %b want 011", {bvalid_o, awready_o, wready_o});
        end
        $display("write: addr 100 mask 0f resp %b", bresp_o);
    endtask

    task automatic test_arbitration();
        int n; int base;
        rready_i = 1; bready_i = 1; base = log_w.size();
        awaddr_i = 28'h200; awvalid_i = 1; wdata_i = 64'h0123_4567_89AB_CDEF; wstrb_i = 8'hFF; wvalid_i = 1;
        tick(); awvalid_i = 0; wvalid_i = 0;
        araddr_i = 28'h300; arvalid_i = 1;
        checks++;
        if (arready_o !== 1'b1) begin errors++; $display("FAIL arb_read_prio got arready=%b want 1", arready_o); end
        tick();                        // contention: read accepted
        araddr_i = 28'h308;            // second read waits behind the write
        n = 0;
        while (log_w.size() < base + 2 && n < 60) begin tick(); n++; end
        n = 0;
        while (!arready_o && n < 60) begin tick(); n++; end
        tick(); arvalid_i = 0;
        n = 0;
        while (log_w.size() < base + 3 && n < 60) begin tick(); n++; end
        repeat (4) tick();
        checks++;
        if (log_w.size() != base + 3) begin
            errors++; $display("FAIL arb_count got %0d want 3", log_w.size() - base);
        end else begin
            checks++;
            if (log_w[base] !== 1'b0 || log_addr[base] !== 25'h60) begin
                errors++; $display("FAIL arb_first got w=%b addr=%h want 0 60", log_w[base], log_addr[base]);
            end
            checks++;
            if (log_w[base+1] !== 1'b1 || log_addr[base+1] !== 25'h40) begin
                errors++; $display("FAIL arb_second got w=%b addr=%h want 1 40", log_w[base+1], log_addr[base+1]);
            end
            checks++;
            if (log_w[base+2] !== 1'b0 || log_addr[base+2] !== 25'h61) begin
                errors++; $display("FAIL arb_third got w=%b addr=%h want 0 61", log_w[base+2], log_addr[base+2]);
            end
        end
        rready_i = 0; bready_i = 0;
        $display("arbitration: order read/write/read observed over %0d cmds", log_w.size() - base);
    endtask

    task automatic test_errors();
        bit to; int n; int base;
        base = cmd_cnt; rready_i = 0;
        ar_send(28'h43, to);
        wait_rvalid(n, to);
        checks++;
        if (to || rresp_o !== 2'b10 || rdata_o !== 64'h0) begin
            errors++; $display("FAIL misaligned_read got resp=%b data=%h want 10 0", rresp_o, rdata_o);
        end
        checks++;
        if (rd_error_o !== 1'b0) begin errors++; $display("FAIL rd_error_early got %b want 0", rd_error_o); end
        rready_i = 1; tick(); rready_i = 0;
        checks++;
        if (rd_error_o !== 1'b1) begin errors++; $display("FAIL rd_error_set got %b want 1", rd_error_o); end
        awaddr_i = 28'h1000; awvalid_i = 1; wdata_i = 64'hFFFF_FFFF_FFFF_FFFF; wstrb_i = 8'hFF; wvalid_i = 1;
        tick(); awvalid_i = 0; wvalid_i = 0;
        wait_bvalid(n, to);
        checks++;
        if (to || bresp_o !== 2'b10) begin errors++; $display("FAIL range_write got resp=%b want 10", bresp_o); end
        checks++;
        if (cmd_cnt != base || mem_v_o !== 1'b0) begin
            errors++; $display("FAIL error_no_mem got cmds=%0d want 0", cmd_cnt - base);
        end
        bready_i = 1; tick(); bready_i = 0;
        checks++;
        if ({wr_error_o, awready_o, wready_o} !== 3'b111) begin
            errors++; $display("FAIL wr_error_set got %b want 111", {wr_error_o, awready_o, wready_o});
        end
        rready_i = 1;
        ar_send(28'h40, to);
        wait_rvalid(n, to);
        tick(); rready_i = 0;
        checks++;
        if ({rd_error_o, wr_error_o} !== 2'b11) begin
            errors++; $display("FAIL errors_sticky got %b want 11", {rd_error_o, wr_error_o});
        end
        $display("errors: rd_error=%b wr_error=%b", rd_error_o, wr_error_o);
    endtask

    task automatic test_backpressure();
        bit to; int n; bit ok;
        memarr[16] = 64'h5555_6666_7777_8888; rready_i = 0;
        ar_send(28'h80, to);
        wait_rvalid(n, to);
        ok = !to;
        for (int i = 0; i < 10; i++) begin
            if (!rvalid_o || rdata_o !== 64'h5555_6666_7777_8888 || rresp_o !== 2'b00 ||
                arready_o || awready_o || wready_o) ok = 0;
            tick();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL r_hold got rvalid=%b data=%h ar=%b want 1 5555666677778888 0", rvalid_o, rdata_o, arready_o); end
        rready_i = 1; tick(); rready_i = 0;
        memarr[17] = 64'h0;
        awaddr_i = 28'h88; awvalid_i = 1; wdata_i = 64'h1234_5678_9ABC_DEF0; wstrb_i = 8'hF0; wvalid_i = 1;
        tick(); awvalid_i = 0; wvalid_i = 0;
        wait_bvalid(n, to);
        ok = !to;
        for (int i = 0; i < 10; i++) begin
            if (!bvalid_o || bresp_o !== 2'b00 || arready_o || awready_o || wready_o || rvalid_o) ok = 0;
            tick();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL b_hold got bvalid=%b aw=%b w=%b want 1 0 0", bvalid_o, awready_o, wready_o); end
        bready_i = 1; tick(); bready_i = 0;
        checks++;
        if (memarr[17] !== 64'h1234_5678_0000_0000) begin
            errors++; $display("FAIL b_hold_mem got %h want 1234567800000000", memarr[17]);
        end
        $display("backpressure: read and write held 10 cycles");
    endtask

    task automatic test_reset_mid();
        bit to; int n;
        rd_lat = 6; rready_i = 1;
        ar_send(28'h40, to);
        tick(); tick();                // in the read-wait state
        #3 reset_i = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL async_reset got %h want 0", all_out); end
        tick(); tick();
        reset_i = 1'b0; rd_pend = 0;
        repeat (3) tick();
        checks++;
        if ({rvalid_o, bvalid_o, mem_v_o} !== 3'b000) begin
            errors++; $display("FAIL abort_no_resp got %b want 000", {rvalid_o, bvalid_o, mem_v_o});
        end
        rd_lat = 1;
        ar_send(28'h40, to);
        wait_rvalid(n, to);
        checks++;
        if (to || rdata_o !== 64'hDEAD_BEEF_0000_0001 || rresp_o !== 2'b00) begin
            errors++; $display("FAIL after_reset_read got data=%h resp=%b want deadbeef00000001 00", rdata_o, rresp_o);
        end
        tick(); rready_i = 0;
        $display("reset_mid: recovered read data %h", rdata_o);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_w_first();
        test_arbitration();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_sub_to_mem.md
Name: axi4_lite_sub_to_mem

Overview:
- AXI4-Lite subordinate (responder) that accepts single-beat 64-bit reads and writes from an AXI4-Lite manager.
- Serializes them onto a simple valid/ready memory command port, e.g. a BRAM or DRAM-controller shim, and returns R/B responses.
- Sits at the far end of the AXI4-Lite link driven by the cache DMA bridge.
- Used as the board-side memory endpoint and as a bench memory model.

Parameters:
- axi_addr_width_p, 28, AXI byte address width.
- axi_data_width_p, 64, AXI data width; must be 64.
- axi_wstrb_width_p, axi_data_width_p/8, write strobe width.
- mem_bytes_p, 2**axi_addr_width_p, size of the addressable region; addresses at or above it are out of range.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- araddr_i  in  axi_addr_width_p  read address
- arprot_i  in  3  read protection
- arvalid_i  in  1  AR valid
- arready_o  out  1  AR ready
- rdata_o  out  axi_data_width_p  read data
- rresp_o  out  2  read response
- rvalid_o  out  1  R valid
- rready_i  in  1  R ready
- awaddr_i  in  axi_addr_width_p  write address
- awprot_i  in  3  write protection
- awvalid_i  in  1  AW valid
- awready_o  out  1  AW ready
- wdata_i  in  axi_data_width_p  write data
- wstrb_i  in  axi_wstrb_width_p  byte enables
- wvalid_i  in  1  W valid
- wready_o  out  1  W ready
- bresp_o  out  2  write response
- bvalid_o  out  1  B valid
- bready_i  in  1  B ready
- mem_v_o  out  1  memory command valid
- mem_w_o  out  1  1=write, 0=read
- mem_addr_o  out  axi_addr_width_p-3  word address, i.e. addr[axi_addr_width_p-1:3]
- mem_data_o  out  axi_data_width_p  write data
- mem_mask_o  out  axi_wstrb_width_p  byte mask
- mem_ready_and_i  in  1  command accepted when mem_v_o & mem_ready_and_i
- mem_data_i  in  axi_data_width_p  read return data
- mem_data_v_i  in  1  read return valid; one cycle, no backpressure
- rd_error_o  out  1  sticky: any SLVERR returned on R
- wr_error_o  out  1  sticky: any SLVERR returned on B

Behaviour:
- Reset: all outputs 0, state e_idle, AW/W capture registers empty, round-robin priority bit = read, sticky errors cleared.
- AW and W are captured independently into one-entry registers.
  - awready_o = ~aw_full & state==e_idle.
  - wready_o = ~w_full & state==e_idle.
  - Either may arrive first or in the same cycle.
- arready_o = state==e_idle & ~rd_blocked; AR is never held in a register, it is accepted only when it will be dispatched.
- Arbitration in e_idle. A write is eligible when aw_full & w_full; a read is eligible when arvalid_i.
  - If both are eligible, the priority bit chooses and then flips to the other side.
  - A lone eligible request wins.
  - rd_blocked = write eligible & priority==write.
- Error check at dispatch: error if addr >= mem_bytes_p or addr[2:0] != 0. An erroring request skips memory and goes straight to the response state with resp 2'b10; otherwise resp 2'b00.
- States:
  - e_idle
  - e_rd_cmd: mem_v_o=1, mem_w_o=0; on handshake go to e_rd_wait.
  - e_rd_wait: capture mem_data_i on mem_data_v_i, then go to e_rd_resp.
  - e_rd_resp: rvalid_o=1, rdata_o held stable; on rready_i go to e_idle.
  - e_wr_cmd: mem_v_o=1, mem_w_o=1, mem_mask_o=wstrb; on handshake clear aw_full and w_full, go to e_wr_resp.
  - e_wr_resp: bvalid_o=1; on bready_i go to e_idle.
- An erroring read returns rdata_o=0. For an erroring write, the capture registers are cleared at dispatch.
- Minimum latency:
  - AR handshake to rvalid_o is 2 cycles plus memory read latency.
  - W/AW completion to bvalid_o is 2 cycles when mem_ready_and_i=1.
- Exactly one outstanding transaction; rvalid_o and bvalid_o are never asserted together.
- mem_data_v_i outside e_rd_wait is ignored.
- Reset mid-transaction aborts immediately, with no response issued.
- Sticky error bits set on the R/B handshake carrying 2'b10.

Optional Feature:
- Macro AXI4_LITE_SUB_PROT_CHECK_EN.
- When defined: a request whose prot[0]==0 (unprivileged) is treated as an error (SLVERR, no memory access).
- When undefined: arprot_i and awprot_i are ignored.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - resp constants e_axi_resp_okay=2'b00, e_axi_resp_slverr=2'b10.
  - state enum axi_sub_state_e.
- One natural sub-module, axi4_lite_sub_wr_capture: AW+W one-entry capture pair with full flags and a joint clear.

Test Plan:
- AR addr 0x40, mem returns 0xDEAD_BEEF_0000_0001 after 3 cycles -> rvalid with that data, rresp 00, mem_addr_o=0x8.
- W arrives 2 cycles before AW (addr 0x100, wstrb 0x0F) -> single mem write, mem_addr_o=0x20, mask 0x0F, bresp 00.
- Simultaneous eligible read and write twice in a row -> read served first, then write, then read (priority alternates).
- AR addr 0x43 (misaligned) and AW addr mem_bytes_p -> no mem_v_o, SLVERR on both responses, rd_error_o and wr_error_o stay 1.
- rready_i/bready_i held low 10 cycles -> response held stable, arready_o/awready_o stay 0.
- Assert reset_i in e_rd_wait -> all outputs 0 asynchronously, next AR serviced normally.
